sync_fifo_ptr_ctrl: RTL and testbench
=====================================

SYNC_FIFO_PTR_CTRL -- requirements
Module: sync_fifo_ptr_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- AW, 8, address index width.
- DEPTH, 150, entries; 2 <= DEPTH <= 2**AW, non-power-of-two legal.
- AF_LVL, DEPTH-4, almost-full threshold.
- AE_LVL, 4, almost-empty threshold.
REQ-002 One clock; reset is asynchronous and active-low; ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- wr_en, in, 1, write request.
- rd_en, in, 1, read request.
- clr_err, in, 1, synchronous clear of sticky error flags.
- mem_we, out, 1, RAM write strobe.
- wr_addr, out, AW, RAM write index.
- mem_re, out, 1, RAM read strobe.
- rd_addr, out, AW, RAM read index.
- fifo_full, out, 1, full flag.
- fifo_empty, out, 1, empty flag.
- almost_full, out, 1, count >= AF_LVL.
- almost_empty, out, 1, count <= AE_LVL.
- count, out, AW+1, occupancy 0..DEPTH.
- overflow, out, 1, sticky write-when-full.
- underflow, out, 1, sticky read-when-empty.

Function
REQ-003 wr_ptr and rd_ptr SHALL each be AW+1-bit registers: MSB = wrap bit, low AW bits = index 0..DEPTH-1.
REQ-004 On an accepted operation, index == DEPTH-1 SHALL go to 0 and toggle the wrap bit; otherwise index+1, wrap bit unchanged.
REQ-005 fifo_empty SHALL be 1 iff wr_ptr == rd_ptr (both fields), combinational from registered pointers.
REQ-006 fifo_full SHALL be 1 iff indices equal and wrap bits differ, combinational from registered pointers.
REQ-007 Write accepted iff wr_en & ~fifo_full; mem_we = accepted write, combinational; wr_addr = wr_ptr index.
REQ-008 Read accepted iff rd_en & ~fifo_empty; mem_re = accepted read, combinational; rd_addr = rd_ptr index; RAM read latency is outside this block.
REQ-009 When full, a write SHALL be rejected even if a read is accepted the same cycle; when empty, a read SHALL be rejected even if a write is accepted the same cycle.
REQ-010 count SHALL be a register: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither; it never leaves 0..DEPTH.
REQ-011 almost_full and almost_empty SHALL be combinational from count.
REQ-012 overflow SHALL set on wr_en & fifo_full; underflow SHALL set on rd_en & fifo_empty; both stay set until clr_err.
REQ-013 If set and clr_err occur in the same cycle, set SHALL win.
REQ-014 Flag and count changes SHALL be visible in the cycle after the accepting edge (1-cycle latency).

Reset
REQ-015 rst_n low SHALL asynchronously clear wr_ptr, rd_ptr, count, overflow and underflow to 0, with no clock required.
REQ-016 During reset: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0 (given AF_LVL>0), mem_we=0, mem_re=0.
REQ-017 Reset asserted mid-operation SHALL discard occupancy; the first accepted write after release SHALL use index 0.

Structure
REQ-018 A shared package SHALL hold the pointer width helper (AW+1) and the default DEPTH/threshold constants.
REQ-019 One sub-module, fifo_wrap_ptr, SHALL implement the wrap-bit counter of REQ-003/004 and be instantiated twice (write, read).

Verification
REQ-020 Bench SHALL use AW=8, DEPTH=150, AF_LVL=146, AE_LVL=4 and cover:
- Reset then idle -> fifo_empty=1, count=0, almost_empty=1, overflow=0.
- 150 consecutive writes -> almost_full=1 after the 146th, fifo_full=1 after the 150th, count=150.
- 151st write -> mem_we=0, overflow=1, count stays 150; clr_err -> overflow=0.
- 150 writes then 150 reads -> rd_addr sequence 0..149, both wrap bits=1, indices 0, fifo_empty=1.
- At count=5, simultaneous rd_en/wr_en for 3 cycles -> count stays 5, both indices advance by 3.
- rst_n low mid-stream at count=70 -> count=0 and fifo_empty=1 immediately; underflow=1 on the next rd_en after release.

Source files
------------

// File: rtl/sync_fifo_ptr_ctrl_pkg.sv
// Shared constants and width helper for the synchronous FIFO pointer controller.
package sync_fifo_ptr_ctrl_pkg;

  localparam int DEF_AW        = 8;
  localparam int DEF_DEPTH     = 150;
  localparam int DEF_AF_MARGIN = 4;
  localparam int DEF_AE_LVL    = 4;

  // Pointer = index bits plus one wrap bit.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrap-bit pointer: index counts 0..DEPTH-1, MSB toggles each time the index wraps.
module fifo_wrap_ptr
  import sync_fifo_ptr_ctrl_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_adv,
  output logic [AW:0] o_ptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW:0]   r_ptr;
  logic [AW-1:0] w_idx;
  logic          w_wrap;

  assign w_idx  = r_ptr[AW-1:0];
  assign w_wrap = r_ptr[AW];
  assign o_ptr  = r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      if (w_idx == LAST) r_ptr <= {~w_wrap, {AW{1'b0}}};
      else               r_ptr <= {w_wrap, w_idx + AW'(1)};
    end
  end

endmodule

// File: rtl/sync_fifo_ptr_ctrl.sv
// Pointer, occupancy and status control for a synchronous FIFO with any depth up to 2**AW.
module sync_fifo_ptr_ctrl
  import sync_fifo_ptr_ctrl_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - DEF_AF_MARGIN,
  parameter int AE_LVL = DEF_AE_LVL
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          clr_err,
  output logic          mem_we,
  output logic [AW-1:0] wr_addr,
  output logic          mem_re,
  output logic [AW-1:0] rd_addr,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int          PW   = ptr_w(AW);
  localparam logic [AW:0] AF_C = PW'(AF_LVL);
  localparam logic [AW:0] AE_C = PW'(AE_LVL);

  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_udf;

  fifo_wrap_ptr #(.AW(AW), .DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_adv (w_wr_acc),
    .o_ptr (w_wr_ptr)
  );

  fifo_wrap_ptr #(.AW(AW), .DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_adv (w_rd_acc),
    .o_ptr (w_rd_ptr)
  );

  assign w_empty = (w_wr_ptr == w_rd_ptr);
  assign w_full  = (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]) && (w_wr_ptr[AW] != w_rd_ptr[AW]);

  // Strobes are gated by rst_n so the RAM sees no access while reset is held.
  assign w_wr_acc = wr_en & ~w_full & rst_n;
  assign w_rd_acc = rd_en & ~w_empty & rst_n;

  assign mem_we       = w_wr_acc;
  assign mem_re       = w_rd_acc;
  assign wr_addr      = w_wr_ptr[AW-1:0];
  assign rd_addr      = w_rd_ptr[AW-1:0];
  assign fifo_full    = w_full;
  assign fifo_empty   = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky errors: a new violation outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wr_en & w_full) r_ovf <= 1'b1;
      else if (clr_err)   r_ovf <= 1'b0;
      if (rd_en & w_empty) r_udf <= 1'b1;
      else if (clr_err)    r_udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ptr_ctrl.sv
// Self-checking bench for sync_fifo_ptr_ctrl against an occupancy/transaction-count model.
module tb_sync_fifo_ptr_ctrl;

  localparam int AW     = 8;
  localparam int DEPTH  = 150;
  localparam int AF_LVL = 146;
  localparam int AE_LVL = 4;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic          rd_en;
  logic          clr_err;
  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic          mem_re;
  logic [AW-1:0] rd_addr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  // Model: total accepted writes/reads (mod 2*DEPTH), occupancy, sticky errors.
  int m_nw, m_nr, m_cnt;
  bit m_ovf, m_udf;

  // Pre-edge expectations and observations from the last cycle.
  bit exp_we, exp_re, obs_we, obs_re;
  int exp_waddr, exp_raddr, obs_waddr, obs_raddr;

  sync_fifo_ptr_ctrl #(
    .AW(AW), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .mem_we       (mem_we),
    .wr_addr      (wr_addr),
    .mem_re       (mem_re),
    .rd_addr      (rd_addr),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_nw = 0; m_nr = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic do_cycle(input bit wr, input bit rd, input bit clr);
    bit wa, ra, m_full, m_empty;
    wr_en = wr; rd_en = rd; clr_err = clr;
    m_full  = (m_cnt == DEPTH);
    m_empty = (m_cnt == 0);
    wa = wr && !m_full;
    ra = rd && !m_empty;
    exp_we = wa; exp_re = ra;
    exp_waddr = m_nw % DEPTH;
    exp_raddr = m_nr % DEPTH;
    #1;
    obs_we = mem_we; obs_re = mem_re;
    obs_waddr = int'(wr_addr); obs_raddr = int'(rd_addr);
    @(posedge clk);
    if (wa) m_nw = (m_nw + 1) % (2 * DEPTH);
    if (ra) m_nr = (m_nr + 1) % (2 * DEPTH);
    m_cnt = m_cnt + int'(wa) - int'(ra);
    if (wr && m_full) m_ovf = 1; else if (clr) m_ovf = 0;
    if (rd && m_empty) m_udf = 1; else if (clr) m_udf = 0;
    #1;
    wr_en = 0; rd_en = 0; clr_err = 0;
  endtask

  // Asserts reset away from a clock edge, holds it across two edges, releases mid-cycle.
  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wr_en = 1; rd_en = 1; clr_err = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0b exp=0", mem_we); end
    checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL rst_mem_re got=%0b exp=0", mem_re); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0b exp=0", fifo_full); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL rst_af got=%0b exp=0", almost_full); end
    wr_en = 0; rd_en = 0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) do_cycle(0, 0, 0);
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL idle_empty got=%0b exp=1", fifo_empty); end
    checks++; if (count !== 9'd0) begin failures++; $display("FAIL idle_count got=%0d exp=0", count); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL idle_ae got=%0b exp=1", almost_empty); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL idle_ovf got=%0b exp=0", overflow); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL idle_udf got=%0b exp=0", underflow); end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      do_cycle(1, 0, 0);
      checks++; if (obs_we !== 1'b1 || obs_waddr != i - 1) begin
        failures++; $display("FAIL fill_we n=%0d got_we=%0b got_addr=%0d exp_addr=%0d", i, obs_we, obs_waddr, i - 1);
      end
      checks++; if (almost_full !== (i >= AF_LVL)) begin
        failures++; $display("FAIL fill_af n=%0d got=%0b exp=%0b", i, almost_full, (i >= AF_LVL));
      end
      checks++; if (fifo_full !== (i == DEPTH)) begin
        failures++; $display("FAIL fill_full n=%0d got=%0b exp=%0b", i, fifo_full, (i == DEPTH));
      end
      checks++; if (int'(count) != i) begin
        failures++; $display("FAIL fill_count n=%0d got=%0d exp=%0d", i, count, i);
      end
    end
    do_cycle(1, 0, 0);
    checks++; if (obs_we !== 1'b0) begin failures++; $display("FAIL ovf_we got=%0b exp=0", obs_we); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
    checks++; if (count !== 9'd150) begin failures++; $display("FAIL ovf_count got=%0d exp=150", count); end
    do_cycle(1, 0, 1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%0b exp=1", overflow); end
    do_cycle(0, 0, 1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%0b exp=0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(0, 1, 0);
      checks++; if (obs_re !== 1'b1 || obs_raddr != i) begin
        failures++; $display("FAIL drain_addr i=%0d got_re=%0b got_addr=%0d exp=%0d", i, obs_re, obs_raddr, i);
      end
    end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b exp=1", fifo_empty); end
    checks++; if (count !== 9'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
    checks++; if (u_dut.u_wr_ptr.o_ptr !== 9'h100) begin
      failures++; $display("FAIL drain_wr_ptr got=%0h exp=100", u_dut.u_wr_ptr.o_ptr);
    end
    checks++; if (u_dut.u_rd_ptr.o_ptr !== 9'h100) begin
      failures++; $display("FAIL drain_rd_ptr got=%0h exp=100", u_dut.u_rd_ptr.o_ptr);
    end
  endtask

  task automatic test_simul();
    apply_reset();
    repeat (5) do_cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1, 1, 0);
      checks++; if (obs_we !== 1'b1 || obs_re !== 1'b1) begin
        failures++; $display("FAIL simul_strobe i=%0d got_we=%0b got_re=%0b exp=11", i, obs_we, obs_re);
      end
      checks++; if (count !== 9'd5) begin failures++; $display("FAIL simul_count i=%0d got=%0d exp=5", i, count); end
    end
    do_cycle(0, 0, 0);
    checks++; if (obs_waddr != 8) begin failures++; $display("FAIL simul_wr_addr got=%0d exp=8", obs_waddr); end
    checks++; if (obs_raddr != 3) begin failures++; $display("FAIL simul_rd_addr got=%0d exp=3", obs_raddr); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (70) do_cycle(1, 0, 0);
    checks++; if (count !== 9'd70) begin failures++; $display("FAIL mid_pre_count got=%0d exp=70", count); end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (count !== 9'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL mid_empty got=%0b exp=1", fifo_empty); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_cycle(0, 1, 0);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL mid_udf got=%0b exp=1", underflow); end
    checks++; if (obs_re !== 1'b0) begin failures++; $display("FAIL mid_re got=%0b exp=0", obs_re); end
    do_cycle(1, 0, 0);
    checks++; if (obs_we !== 1'b1 || obs_waddr != 0) begin
      failures++; $display("FAIL mid_first_wr got_we=%0b got_addr=%0d exp_addr=0", obs_we, obs_waddr);
    end
  endtask

  task automatic test_random();
    int pw;
    apply_reset();
    for (int i = 0; i < 1200; i++) begin
      pw = ((i / 300) % 2 == 0) ? 85 : 15;
      do_cycle($urandom_range(99) < pw, $urandom_range(99) < (100 - pw), $urandom_range(99) < 5);
      checks++; if (obs_we !== exp_we || obs_re !== exp_re) begin
        failures++; $display("FAIL rnd_strobe c=%0d got=%0b%0b exp=%0b%0b", i, obs_we, obs_re, exp_we, exp_re);
      end
      checks++; if (obs_waddr != exp_waddr || obs_raddr != exp_raddr) begin
        failures++; $display("FAIL rnd_addr c=%0d got=%0d/%0d exp=%0d/%0d", i, obs_waddr, obs_raddr, exp_waddr, exp_raddr);
      end
      checks++; if (int'(count) != m_cnt) begin
        failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", i, count, m_cnt);
      end
      checks++; if (fifo_full !== (m_cnt == DEPTH) || fifo_empty !== (m_cnt == 0)) begin
        failures++; $display("FAIL rnd_fe c=%0d got=%0b%0b exp=%0b%0b", i, fifo_full, fifo_empty, (m_cnt == DEPTH), (m_cnt == 0));
      end
      checks++; if (almost_full !== (m_cnt >= AF_LVL) || almost_empty !== (m_cnt <= AE_LVL)) begin
        failures++; $display("FAIL rnd_almost c=%0d got=%0b%0b exp=%0b%0b", i, almost_full, almost_empty, (m_cnt >= AF_LVL), (m_cnt <= AE_LVL));
      end
      checks++; if (overflow !== m_ovf || underflow !== m_udf) begin
        failures++; $display("FAIL rnd_err c=%0d got=%0b%0b exp=%0b%0b", i, overflow, underflow, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 0; rd_en = 0; clr_err = 0;
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_simul();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
